// File: rtl/mem_arbiter.sv
// mem_arbiter
// Memory-side responder that arbitrates dcache and icache word requests onto
// one RAM port and answers each requester with the wait/load handshake:
// wait stays high until the word completes, then drops for exactly one cycle.
//
// Parameters:
//   STARVE_MAX  consecutive dcache completions tolerated while iREN is pending
//               before the icache is forced in (fits a 3-bit counter)
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   dREN, dWEN, daddr, dstore     dcache request (write wins over read)
//   dwait, dload                  dcache handshake / read data
//   iREN, iaddr                   icache read request
//   iwait, iload                  icache handshake / read data
//   ramREN, ramWEN, ramaddr,
//   ramstore                      RAM command
//   ramload, ramstate             RAM read data and status
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] RAM_ACCESS   = 2'd2;
  localparam logic [1:0] RAM_ERROR    = 2'd3;
  localparam logic [2:0] STARVE_MAX_C = 3'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DGNT   = 3'd1,
    IGNT   = 3'd2,
    DRETRY = 3'd3,
    IRETRY = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [2:0]  starve_cnt_r;
  logic        starving_s;
  logic        d_done_s;
  logic        i_done_s;
  logic        d_req_s;

  assign d_req_s    = dREN | dWEN;
  assign starving_s = iREN && (starve_cnt_r == STARVE_MAX_C);

  // Grant state register; reset returns to IDLE at once, which drops the
  // RAM enables asynchronously because all outputs decode from state_r.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Fairness counter: counts dcache completions seen while the icache waits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt_r <= 3'd0;
    end else if (d_done_s) begin
      if (!iREN) begin
        starve_cnt_r <= 3'd0;
      end else if (starve_cnt_r != STARVE_MAX_C) begin
        starve_cnt_r <= starve_cnt_r + 3'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else if (i_done_s) begin
      starve_cnt_r <= 3'd0;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Next-state and output decode; RAM command comes only from the grant state.
  always_comb begin
    next_state_s = state_r;
    dwait        = 1'b1;
    iwait        = 1'b1;
    dload        = 32'h0000_0000;
    iload        = 32'h0000_0000;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = 32'h0000_0000;
    ramstore     = 32'h0000_0000;
    d_done_s     = 1'b0;
    i_done_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (d_req_s && !starving_s) begin
          next_state_s = DGNT;
        end else if (iREN) begin
          next_state_s = IGNT;
        end else begin
          next_state_s = IDLE;
        end
      end

      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        // A withdrawn request never completes, even if the RAM reports ACCESS.
        if (!d_req_s) begin
          next_state_s = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait        = 1'b0;
          dload        = ramload;
          d_done_s     = 1'b1;
          next_state_s = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          next_state_s = DRETRY;
        end else begin
          next_state_s = DGNT;
        end
      end

      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          next_state_s = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait        = 1'b0;
          iload        = ramload;
          i_done_s     = 1'b1;
          next_state_s = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          next_state_s = IRETRY;
        end else begin
          next_state_s = IGNT;
        end
      end

      DRETRY: begin
        next_state_s = DGNT;
      end

      IRETRY: begin
        next_state_s = IGNT;
      end

      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter: drives cache requests and RAM status by
// hand and compares the handshake/RAM outputs against hand-computed values.
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_cmp;
  int n_err;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    RST      = 1'b1;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'h0;
    dstore   = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    ramload  = 32'h0;
    ramstate = FREE;

    // Reset values
    #2;
    chk("rst_dwait", dwait, 32'd1);
    chk("rst_iwait", iwait, 32'd1);
    chk("rst_dload", dload, 32'h0);
    chk("rst_iload", iload, 32'h0);
    chk("rst_ramREN", ramREN, 32'd0);
    chk("rst_ramWEN", ramWEN, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    tick();
    RST = 1'b0;

    // Read completion: ACCESS three cycles after ramREN rises
    dREN = 1'b1; daddr = 32'h0000_0100; ramstate = FREE;
    #1;
    chk("rd_idle_ramREN", ramREN, 32'd0);
    tick();
    ramstate = BUSY;
    #1;
    chk("rd_ramREN", ramREN, 32'd1);
    chk("rd_ramWEN", ramWEN, 32'd0);
    chk("rd_ramaddr", ramaddr, 32'h0000_0100);
    chk("rd_busy_dwait1", dwait, 32'd1);
    tick();
    chk("rd_busy_dwait2", dwait, 32'd1);
    tick();
    chk("rd_busy_dwait3", dwait, 32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    #1;
    chk("rd_dwait_low", dwait, 32'd0);
    chk("rd_dload", dload, 32'hDEAD_BEEF);
    chk("rd_iwait", iwait, 32'd1);
    tick();
    dREN = 1'b0; ramstate = FREE;
    #1;
    chk("rd_pulse_end", dwait, 32'd1);
    chk("rd_idle_dload", dload, 32'h0);
    chk("rd_idle_ramREN2", ramREN, 32'd0);

    // Write, with dREN also high (treated as a write)
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h0000_0204; dstore = 32'h1234_5678;
    tick();
    ramstate = BUSY;
    #1;
    chk("wr_ramWEN", ramWEN, 32'd1);
    chk("wr_ramREN", ramREN, 32'd0);
    chk("wr_ramaddr", ramaddr, 32'h0000_0204);
    chk("wr_ramstore", ramstore, 32'h1234_5678);
    tick();
    ramstate = ACCESS;
    #1;
    chk("wr_ramWEN2", ramWEN, 32'd1);
    chk("wr_ramREN2", ramREN, 32'd0);
    chk("wr_dwait_low", dwait, 32'd0);
    tick();
    dWEN = 1'b0; dREN = 1'b0; ramstate = FREE;
    #1;
    chk("wr_idle_ramstore", ramstore, 32'h0);
    chk("wr_idle_ramWEN", ramWEN, 32'd0);

    // Simultaneous requests: dcache first, then icache
    iREN = 1'b1; iaddr = 32'h0; dREN = 1'b1; daddr = 32'h0000_0040;
    ramstate = ACCESS; ramload = 32'hA5A5_0001;
    #1;
    chk("sim_idle_dwait", dwait, 32'd1);
    chk("sim_idle_iwait", iwait, 32'd1);
    tick();
    chk("sim_d_ramaddr", ramaddr, 32'h0000_0040);
    chk("sim_d_dwait", dwait, 32'd0);
    chk("sim_d_iwait", iwait, 32'd1);
    tick();
    dREN = 1'b0; ramload = 32'hA5A5_0002;
    #1;
    chk("sim_idle2_ramREN", ramREN, 32'd0);
    chk("sim_idle2_ramaddr", ramaddr, 32'h0);
    tick();
    chk("sim_i_ramREN", ramREN, 32'd1);
    chk("sim_i_iwait", iwait, 32'd0);
    chk("sim_i_iload", iload, 32'hA5A5_0002);
    chk("sim_i_dwait", dwait, 32'd1);
    tick();
    iREN = 1'b0;
    #1;
    chk("sim_i_pulse_end", iwait, 32'd1);

    // Starvation: four dcache words, then the icache is forced in
    dREN = 1'b1; daddr = 32'h0000_0300; iREN = 1'b1; iaddr = 32'h0000_0080;
    ramstate = ACCESS; ramload = 32'h0BAD_CAFE;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("stv_d%0d_dwait", k), dwait, 32'd0);
      chk($sformatf("stv_d%0d_ramaddr", k), ramaddr, 32'h0000_0300);
      tick();
      chk($sformatf("stv_idle%0d_ramREN", k), ramREN, 32'd0);
    end
    tick();
    chk("stv_i_iwait", iwait, 32'd0);
    chk("stv_i_ramaddr", ramaddr, 32'h0000_0080);
    chk("stv_i_dwait", dwait, 32'd1);
    tick();
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
    #1;
    chk("stv_idle_end", ramREN, 32'd0);

    // ERROR retry
    dREN = 1'b1; daddr = 32'h0000_0500; ramload = 32'hCAFE_F00D;
    tick();
    ramstate = ERROR;
    #1;
    chk("err_ramREN", ramREN, 32'd1);
    chk("err_dwait", dwait, 32'd1);
    tick();
    ramstate = ACCESS;
    #1;
    chk("err_retry_ramREN", ramREN, 32'd0);
    chk("err_retry_ramWEN", ramWEN, 32'd0);
    chk("err_retry_ramaddr", ramaddr, 32'h0);
    chk("err_retry_dwait", dwait, 32'd1);
    tick();
    chk("err_reissue_ramaddr", ramaddr, 32'h0000_0500);
    chk("err_reissue_ramREN", ramREN, 32'd1);
    chk("err_done_dwait", dwait, 32'd0);
    chk("err_done_dload", dload, 32'hCAFE_F00D);
    tick();
    dREN = 1'b0; ramstate = FREE;
    #1;
    chk("err_idle_dwait", dwait, 32'd1);

    // Reset asserted mid-grant
    dREN = 1'b1; daddr = 32'h0000_0600; dstore = 32'h7777_0000;
    tick();
    ramstate = BUSY;
    #1;
    chk("rstg_ramREN", ramREN, 32'd1);
    RST = 1'b1;
    #1;
    chk("rstg_ramREN_low", ramREN, 32'd0);
    chk("rstg_ramaddr", ramaddr, 32'h0);
    chk("rstg_ramstore", ramstore, 32'h0);
    ramstate = ACCESS;
    #1;
    chk("rstg_no_pulse", dwait, 32'd1);
    tick();
    RST = 1'b0; ramstate = BUSY;
    #1;
    chk("rstg_idle_ramREN", ramREN, 32'd0);
    tick();
    chk("rstg_regrant_ramREN", ramREN, 32'd1);
    chk("rstg_regrant_ramaddr", ramaddr, 32'h0000_0600);

    // Withdrawal mid-grant: enables drop the same cycle, IDLE next
    dREN = 1'b0;
    ramstate = ACCESS;
    #1;
    chk("wd_ramREN", ramREN, 32'd0);
    chk("wd_dwait", dwait, 32'd1);
    tick();
    iREN = 1'b1; iaddr = 32'h0000_0900; ramload = 32'h1357_9BDF;
    #1;
    chk("wd_idle_iwait", iwait, 32'd1);
    chk("wd_idle_ramaddr", ramaddr, 32'h0);
    tick();
    chk("wd_i_iwait", iwait, 32'd0);
    chk("wd_i_iload", iload, 32'h1357_9BDF);
    tick();
    iREN = 1'b0; ramstate = FREE;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the cache request protocol. Accepts word requests from the dcache (dREN/dWEN/daddr/dstore) and icache (iREN/iaddr), arbitrates them onto the single RAM port, and answers each requester with the wait/load handshake it expects: wait high until the word completes, then low for exactly one cycle. Sits between the caches and the RAM model, one level below both caches.

## Interface
- STARVE_MAX, default 4: number of consecutive dcache grants allowed while iREN is pending before the icache is forced in.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both are high.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for one cycle when the dcache word completes.
- dload  out  32  read data; valid in the dwait-low cycle.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for one cycle when the icache word completes.
- iload  out  32  read data; valid in the iwait-low cycle.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
States: IDLE, DGNT, IGNT, DRETRY, IRETRY. The grant is registered, so the RAM signals come only from the current state, never from request inputs through a combinational path from IDLE.

- **IDLE**
  - All RAM enables are 0; dwait=iwait=1.
  - Next state is chosen from the requests sampled this cycle:
    - (dREN|dWEN) and not starving -> DGNT.
    - Else iREN -> IGNT.
    - Else stay in IDLE.
  - "Starving" means iREN=1 and starve_cnt==STARVE_MAX.
- **DGNT**
  - Drive ramaddr=daddr and ramstore=dstore.
  - Drive ramWEN=dWEN and ramREN=dREN&~dWEN. Address and data follow the live inputs, so the cache may change daddr between words.
  - ramstate==ACCESS: dwait=0, dload=ramload, then -> IDLE.
  - ramstate==ERROR: -> DRETRY.
  - dREN=dWEN=0 (request withdrawn): enables go low the same cycle, no completion, then -> IDLE.
- **IGNT**
  - Drive ramREN=iREN and ramaddr=iaddr; ramWEN=0.
  - ACCESS: iwait=0, iload=ramload, then -> IDLE.
  - ERROR: -> IRETRY.
  - iREN=0: -> IDLE.
- **DRETRY / IRETRY**
  - One cycle with all enables low and wait held high.
  - Then return to DGNT or IGNT and re-issue the same word.
- **Fairness**
  - starve_cnt is 3 bits, saturating at STARVE_MAX.
  - It increments on each dcache completion while iREN=1.
  - It clears on each icache completion, and when iREN=0 at a dcache completion.
- **Multi-word transfers**
  - A cache load or writeback of a two-word block is two independent word transactions. Arbitration happens again in IDLE between them.
- **Unused outputs**
  - dload and iload are 0 when their wait is high.
  - ramstore is 0 outside DGNT.
  - ramaddr is 0 in IDLE and in the retry states.

## Timing
- **Reset**
  - state=IDLE, starve_cnt=0, dwait=1, iwait=1.
  - dload, iload, ramREN, ramWEN, ramaddr and ramstore are all 0.
  - Reset asserted mid-transaction drops the RAM enables immediately (asynchronously) with no completion pulse.
- **Latency**
  - Request high in cycle N (state IDLE) -> RAM enable high in cycle N+1.
  - wait goes low in the first cycle at or after N+1 in which ramstate==ACCESS.
  - Minimum request-to-completion is 2 cycles.
- **Pulse width**
  - wait is low for exactly one cycle per word.
  - The controller is in IDLE in the following cycle. A requester that keeps its request high gets re-arbitrated there, giving at least 1 idle cycle between words.
- **Simultaneous requests in IDLE**
  - dcache wins unless starving.
  - dWEN and dREN together is treated as a write.
- **Single grant**
  - dwait and iwait are never low in the same cycle.
  - ramREN and ramWEN are never both high.
- **Ignored status**
  - ramstate is ignored in IDLE and in the retry states.

## Test plan
- **Read completion:** dREN=1, daddr=0x100, ramstate goes ACCESS 3 cycles after ramREN rises with ramload=0xDEADBEEF -> dwait low for exactly one cycle with dload=0xDEADBEEF; iwait stays 1.
- **Write:** dWEN=1, daddr=0x204, dstore=0x12345678 -> ramWEN=1, ramaddr=0x204, ramstore=0x12345678 from the next cycle until ACCESS; ramREN=0 throughout.
- **Simultaneous requests:** iREN=1 (0x0) and dREN=1 (0x40) together -> dcache served first, icache served in the next grant.
- **Starvation:** with STARVE_MAX=4, dREN and iREN held high -> after 4 dcache completions the 5th grant goes to the icache.
- **ERROR retry:** ERROR returned on the first attempt -> one cycle with enables low, then the same address re-issued; the completion pulse occurs only on ACCESS.
- **Reset and withdrawal:** RST pulsed while in DGNT -> all outputs return to reset values with no dwait pulse, and the next request after RST falls starts from IDLE. dREN dropped mid-grant -> enables low the same cycle, IDLE next.
